// File: rtl/mem_bus_if_if.sv
// Memory-side bus bundle between the controller bus unit (master) and data memory (slave).
interface mem_bus_if_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic [AW-1:0] mem_addr;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_addr, mem_req, mem_we, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_req, mem_we, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_bus_if.sv
// Turns level-type rd/wr strobes into single req/ack memory transactions,
// latches read data and aborts transactions whose ack never arrives.
module mem_bus_if #(
    parameter int AW      = 5,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic          rd,
    input  logic          wr,
    input  logic          data_e,
    input  logic [AW-1:0] pc_addr,
    input  logic [AW-1:0] ir_addr,
    input  logic [DW-1:0] ac_data,
    input  logic          err_clr,
    output logic [DW-1:0] data_out,
    output logic          data_valid,
    output logic          busy,
    output logic          bus_err,
    output logic          proto_err,
    mem_bus_if_if.master  mem
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t        state_reg, state_next;
    logic [7:0]    cnt_reg, cnt_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [DW-1:0] wdata_reg, wdata_next;
    logic [DW-1:0] data_reg, data_next;
    logic          dv_reg, dv_next;
    logic          bus_err_reg, bus_err_next;
    logic          proto_err_reg, proto_err_next;
    logic          rd_q_reg, wr_q_reg;

    logic          wr_en, rd_rise, wr_rise;
    logic [AW-1:0] addr_sel;

    assign wr_en    = wr & data_e;
    assign rd_rise  = rd & ~rd_q_reg;
    assign wr_rise  = wr_en & ~wr_q_reg;
    assign addr_sel = sel ? pc_addr : ir_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            data_reg      <= '0;
            dv_reg        <= 1'b0;
            bus_err_reg   <= 1'b0;
            proto_err_reg <= 1'b0;
            rd_q_reg      <= 1'b0;
            wr_q_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            data_reg      <= data_next;
            dv_reg        <= dv_next;
            bus_err_reg   <= bus_err_next;
            proto_err_reg <= proto_err_next;
            rd_q_reg      <= rd;
            wr_q_reg      <= wr_en;
        end
    end

    // Error flags clear on err_clr, but a fresh error on the same edge keeps them set.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        data_next      = data_reg;
        dv_next        = 1'b0;
        bus_err_next   = bus_err_reg & ~err_clr;
        proto_err_next = proto_err_reg & ~err_clr;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (wr_rise) begin
                    state_next = WRITE;
                    addr_next  = addr_sel;
                    wdata_next = ac_data;
                    if (rd_rise)
                        proto_err_next = 1'b1;
                end else if (rd_rise) begin
                    state_next = READ;
                    addr_next  = addr_sel;
                end
            end
            READ, WRITE: begin
                if (rd_rise || wr_rise)
                    proto_err_next = 1'b1;
                // Ack is checked before the timeout so a last-moment ack still completes.
                if (mem.mem_ack) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    if (state_reg == READ) begin
                        data_next = mem.mem_rdata;
                        dv_next   = 1'b1;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    bus_err_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy          = (state_reg != IDLE);
    assign mem.mem_req   = (state_reg != IDLE);
    assign mem.mem_we    = (state_reg == WRITE);
    assign mem.mem_addr  = addr_reg;
    assign mem.mem_wdata = wdata_reg;
    assign data_out      = data_reg;
    assign data_valid    = dv_reg;
    assign bus_err       = bus_err_reg;
    assign proto_err     = proto_err_reg;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: the bench plays the memory and drives ack by hand.
module tb_mem_bus_if;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0, rd = 1'b0, wr = 1'b0, data_e = 1'b0, err_clr = 1'b0;
    logic [4:0] pc_addr = '0, ir_addr = '0;
    logic [7:0] ac_data = '0;
    logic [7:0] data_out;
    logic       data_valid, busy, bus_err, proto_err;

    int checks = 0;
    int errors = 0;

    mem_bus_if_if #(.AW(5), .DW(8)) mem ();

    mem_bus_if #(.AW(5), .DW(8), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .rd         (rd),
        .wr         (wr),
        .data_e     (data_e),
        .pc_addr    (pc_addr),
        .ir_addr    (ir_addr),
        .ac_data    (ac_data),
        .err_clr    (err_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .bus_err    (bus_err),
        .proto_err  (proto_err),
        .mem        (mem.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_req", mem.mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_errs", {bus_err, proto_err}, 0);

        // Zero-wait read from PC
        sel = 1'b1; pc_addr = 5'h03; ir_addr = 5'h0A; rd = 1'b1;
        tick();
        chk("rd_req", mem.mem_req, 1);
        chk("rd_we", mem.mem_we, 0);
        chk("rd_addr", mem.mem_addr, 5'h03);
        mem.mem_ack = 1'b1; mem.mem_rdata = 8'hA5;
        tick();
        chk("rd_dout", data_out, 8'hA5);
        chk("rd_dv", data_valid, 1);
        chk("rd_req_done", mem.mem_req, 0);
        mem.mem_ack = 1'b0; rd = 1'b0;
        tick();
        chk("rd_dv_pulse", data_valid, 0);
        chk("rd_one_req", mem.mem_req, 0);
        chk("rd_proto", proto_err, 0);
        $display("txn zero-wait read addr=03 data=%0h", data_out);

        // Write from IR operand, ack on the fourth edge
        sel = 1'b0; ir_addr = 5'h1F; ac_data = 8'h3C; wr = 1'b1; data_e = 1'b1;
        tick();
        wr = 1'b0; data_e = 1'b0; ac_data = 8'h77; ir_addr = 5'h02;
        for (int i = 0; i < 4; i++) begin
            chk("wr_req", mem.mem_req, 1);
            chk("wr_we", mem.mem_we, 1);
            chk("wr_wdata", mem.mem_wdata, 8'h3C);
            chk("wr_addr", mem.mem_addr, 5'h1F);
            if (i == 3) mem.mem_ack = 1'b1;
            tick();
        end
        mem.mem_ack = 1'b0;
        chk("wr_busy_done", busy, 0);
        chk("wr_no_dv", data_valid, 0);
        chk("wr_dout_kept", data_out, 8'hA5);
        $display("txn write addr=1f data=3c");

        // Timeout: never ack
        sel = 1'b1; pc_addr = 5'h10; rd = 1'b1;
        tick();
        rd = 1'b0;
        repeat (14) tick();
        chk("to_busy_14", busy, 1);
        chk("to_err_14", bus_err, 0);
        tick();
        chk("to_req", mem.mem_req, 0);
        chk("to_bus_err", bus_err, 1);
        chk("to_dout", data_out, 8'hA5);
        chk("to_dv", data_valid, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_clr", bus_err, 0);
        $display("txn read timeout addr=10");

        // Ack on the timeout edge
        rd = 1'b1;
        tick();
        rd = 1'b0;
        repeat (14) tick();
        mem.mem_ack = 1'b1; mem.mem_rdata = 8'h5A;
        tick();
        mem.mem_ack = 1'b0;
        chk("ato_req", mem.mem_req, 0);
        chk("ato_dout", data_out, 8'h5A);
        chk("ato_dv", data_valid, 1);
        chk("ato_err", bus_err, 0);
        $display("txn read ack-on-timeout-edge data=%0h", data_out);

        // Collision, then rises while busy
        sel = 1'b0; ir_addr = 5'h07; ac_data = 8'hC3; rd = 1'b1; wr = 1'b1; data_e = 1'b1;
        tick();
        chk("col_we", mem.mem_we, 1);
        chk("col_addr", mem.mem_addr, 5'h07);
        chk("col_wdata", mem.mem_wdata, 8'hC3);
        chk("col_proto", proto_err, 1);
        rd = 1'b0; wr = 1'b0; data_e = 1'b0; err_clr = 1'b1;
        tick();
        chk("col_clr", proto_err, 0);
        err_clr = 1'b0; rd = 1'b1; sel = 1'b1;
        tick();
        chk("busy_rd_proto", proto_err, 1);
        chk("busy_rd_we", mem.mem_we, 1);
        chk("busy_rd_addr", mem.mem_addr, 5'h07);
        rd = 1'b0;
        tick();
        err_clr = 1'b1; rd = 1'b1;
        tick();
        chk("clr_vs_new", proto_err, 1);
        err_clr = 1'b0; rd = 1'b0; mem.mem_ack = 1'b1;
        tick();
        mem.mem_ack = 1'b0;
        chk("col_done", busy, 0);
        tick();
        chk("col_no_2nd", mem.mem_req, 0);
        $display("txn collision write addr=07 proto_err=%0b", proto_err);

        // Reset in the middle of a read
        sel = 1'b1; pc_addr = 5'h08; rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
        tick();
        chk("mr_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("mr_req", mem.mem_req, 0);
        chk("mr_busy", busy, 0);
        chk("mr_dv", data_valid, 0);
        chk("mr_errs", {bus_err, proto_err}, 0);
        mem.mem_ack = 1'b1; mem.mem_rdata = 8'hEE;
        tick();
        rst = 1'b0;
        tick();
        chk("late_ack_dout", data_out, 0);
        chk("late_ack_dv", data_valid, 0);
        chk("late_ack_req", mem.mem_req, 0);
        mem.mem_ack = 1'b0;
        $display("txn reset mid-read addr=08");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
